// File: rtl/mod_reduce_pkg.sv
`default_nettype none
// +-- mod_reduce_pkg : shared FSM type, modulus helper and 25519 defaults ------------+
// +-- rev 1.0 ------------------------------------------------------------------------+
package mod_reduce_pkg;

  localparam int unsigned DEF_N  = 255;
  localparam int unsigned DEF_C  = 19;
  localparam int unsigned P_MAXW = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Wide enough for any 2N <= P_MAXW; callers slice down to their own width.
  function automatic logic [P_MAXW-1:0] calc_p(input int unsigned n, input int unsigned c);
    logic [P_MAXW-1:0] one;
    one = {{(P_MAXW-1){1'b0}}, 1'b1};
    return (one << n) - P_MAXW'(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_fold.sv
`default_nettype none
// +-- mod_fold : combinational lo + hi*C, the folding step of the pseudo-Mersenne reducer --+
// +-- rev 1.0 ------------------------------------------------------------------------------+
module mod_fold #(
  parameter  int unsigned N  = 255,
  parameter  int unsigned C  = 19,
  localparam int unsigned CW = $clog2(C) + 1
) (
  input  logic [N-1:0]  lo_i,
  input  logic [N-1:0]  hi_i,
  output logic [N+CW:0] sum_o
);

  localparam int unsigned SW = N + CW + 1;
  localparam logic [CW-1:0] C_VEC = CW'(C);

  // Full-width arithmetic: the product can never be truncated.
  assign sum_o = SW'(lo_i) + SW'(hi_i) * SW'(C_VEC);

endmodule
`default_nettype wire

// File: rtl/mod_reduce_seq.sv
`default_nettype none
// +-- mod_reduce_seq : iterative reduction of a 2N-bit value modulo p = 2^N - C, ready/valid --+
// +-- rev 1.0 ---------------------------------------------------------------------------------+
module mod_reduce_seq
  import mod_reduce_pkg::*;
#(
  parameter  int unsigned N  = DEF_N,
  parameter  int unsigned C  = DEF_C,
  localparam int unsigned CW = $clog2(C) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   r,
  output logic           busy
);

  localparam logic [P_MAXW-1:0] P_FULL = calc_p(N, C);
  localparam logic [2*N-1:0]    P      = P_FULL[2*N-1:0];

  // Folding only converges when C stays below 2^(N/2).
  localparam bit C_ZERO = (C == 0);
  localparam bit C_BIG  = (N / 2 < 32) && (C >= (32'd1 << (N / 2)));

  generate
    if (C_ZERO || C_BIG || (2 * N > P_MAXW)) begin : g_bad_param
      $error("mod_reduce_seq: illegal parameters, need 1 <= C < 2^(N/2) and 2N <= P_MAXW");
    end
  endgenerate

  state_e           state_q;
  logic [2*N-1:0]   acc_q;
  logic [N-1:0]     r_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [N+CW:0]    fold_sum;

  mod_fold #(
    .N (N),
    .C (C)
  ) u_fold (
    .lo_i  (acc_q[N-1:0]),
    .hi_i  (acc_q[2*N-1:N]),
    .sum_o (fold_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= n;
            state_q    <= FOLD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        FOLD: begin
          if (acc_q[2*N-1:N] != '0) begin
            acc_q <= (2*N)'(fold_sum);
          end else begin
            state_q <= SUB;
          end
        end
        SUB: begin
          if (acc_q >= P) begin
            acc_q <= acc_q - P;
          end else begin
            r_q         <= acc_q[N-1:0];
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // in_ready only rises after the handshake edge, so DONE never accepts directly.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +-- tb_mod_reduce_seq : directed + random checks of mod_reduce_seq (N=255/C=19, N=8/C=5) --+
// +-- rev 1.0 -------------------------------------------------------------------------------+
module tb_mod_reduce_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv1, ir1, ov1, or1, busy1;
  logic [509:0] n1;
  logic [254:0] r1;

  logic         iv2, ir2, ov2, or2, busy2;
  logic [15:0]  n2;
  logic [7:0]   r2;

  logic [7:0]   f_lo, f_hi;
  logic [12:0]  f_sum;

  logic [509:0] p1;
  int total = 0;
  int bad   = 0;

  mod_reduce_seq u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .n(n1),
    .out_valid(ov1), .out_ready(or1), .r(r1), .busy(busy1)
  );

  mod_reduce_seq #(.N(8), .C(5)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .n(n2),
    .out_valid(ov2), .out_ready(or2), .r(r2), .busy(busy2)
  );

  mod_fold #(.N(8), .C(5)) u_fold (.lo_i(f_lo), .hi_i(f_hi), .sum_o(f_sum));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept1(input logic [509:0] v);
    int k;
    k = 0;
    n1  = v;
    iv1 = 1'b1;
    while (!ir1 && k < 50) begin @(posedge clk); #1; k++; end
    check("accept1_ready", ir1, 1);
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  // Latency counts clock edges from (and including) the accept edge.
  task automatic wait_valid1(output int lat);
    lat = 1;
    while (!ov1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("valid1_timeout", ov1, 1);
  endtask

  task automatic op1(input string tag, input logic [509:0] v, output int lat);
    accept1(v);
    wait_valid1(lat);
    check(tag, r1, v % p1);
    @(posedge clk); #1;
  endtask

  task automatic op2(input string tag, input logic [15:0] v);
    int k;
    k = 0;
    n2  = v;
    iv2 = 1'b1;
    while (!ir2 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    iv2 = 1'b0;
    k = 0;
    while (!ov2 && k < 40) begin @(posedge clk); #1; k++; end
    check({tag, "_valid"}, ov2, 1);
    check(tag, r2, v % 16'd251);
    @(posedge clk); #1;
  endtask

  initial begin
    int           lat;
    logic [511:0] tmp;
    logic [509:0] v;
    logic [254:0] rsave;

    iv1 = 1'b0; or1 = 1'b1; n1 = '0;
    iv2 = 1'b0; or2 = 1'b1; n2 = '0;
    f_lo = '0; f_hi = '0;
    p1 = (510'd1 << 255) - 510'd19;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ir1, 1);
    check("rst_out_valid", ov1, 0);
    check("rst_busy", busy1, 0);
    check("rst_r", r1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Smallest operand: no fold, no subtract.
    accept1(510'd2);
    check("busy_after_accept", busy1, 1);
    check("in_ready_after_accept", ir1, 0);
    wait_valid1(lat);
    check("n2_r", r1, 2);
    check("n2_latency", lat, 3);
    @(posedge clk); #1;
    check("post_hs_out_valid", ov1, 0);
    check("post_hs_in_ready", ir1, 1);
    check("post_hs_busy", busy1, 0);

    op1("ones_r", {510{1'b1}}, lat);
    check("ones_r_const", r1, 360);
    check("ones_latency", lat, 6);

    tmp = {16{32'hdeadbeef}};
    tmp = tmp << 1;
    op1("deadbeef_r", tmp[509:0], lat);

    op1("n_eq_p", p1, lat);
    check("n_eq_p_const", r1, 0);
    op1("n_p_minus_1", p1 - 510'd1, lat);
    check("n_p_minus_1_const", r1, (255'd1 << 255) - 255'd20);
    op1("n_2pow255", 510'd1 << 255, lat);
    check("n_2pow255_const", r1, 19);
    op1("n_zero", 510'd0, lat);
    check("n_zero_const", r1, 0);
    // Top of [p, 2^N-1]: a single subtract and no fold.
    op1("n_2pow255_m1", (510'd1 << 255) - 510'd1, lat);
    check("n_2pow255_m1_latency", lat, 4);

    // Backpressure with ignored input pulses.
    or1 = 1'b0;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 30'($urandom)};
    accept1(v);
    wait_valid1(lat);
    rsave = r1;
    check("bp_r", rsave, v % p1);
    for (int k = 0; k < 20; k++) begin
      iv1 = (k % 2 == 0);
      n1  = 510'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", ov1, 1);
      check("bp_r_stable", r1, rsave);
      check("bp_in_ready", ir1, 0);
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", ov1, 0);
    check("bp_release_in_ready", ir1, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("bp_idle_out_valid", ov1, 0);
      check("bp_idle_busy", busy1, 0);
    end

    // Reset in the middle of folding.
    accept1({510{1'b1}});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_in_ready", ir1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("midrst_no_stale", ov1, 0);
    end
    op1("after_rst_n5", 510'd5, lat);
    check("after_rst_n5_const", r1, 5);

    for (int k = 0; k < 30; k++) begin
      for (int w = 0; w < 16; w++) tmp = {tmp[479:0], 32'($urandom)};
      v = tmp[509:0];
      if (k % 3 == 0) v[509:255] = '0;
      op1("rand255", v, lat);
    end

    op2("n8_ffff", 16'hFFFF);
    check("n8_ffff_const", r2, 24);
    op2("n8_251", 16'd251);
    check("n8_251_const", r2, 0);
    op2("n8_250", 16'd250);
    check("n8_250_const", r2, 250);
    for (int k = 0; k < 1000; k++) begin
      op2("rand8", 16'($urandom_range(0, 65535)));
    end

    for (int k = 0; k < 16; k++) begin
      f_lo = 8'($urandom_range(0, 255));
      f_hi = 8'($urandom_range(0, 255));
      #1;
      check("fold_unit", f_sum, 13'(int'(f_lo) + int'(f_hi) * 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
